prbs5_checker: RTL and testbench

PRBS5_CHECKER -- requirements
Module: prbs5_checker

---
 rtl/prbs5_checker_if.sv | 23 ++
 rtl/prbs5_checker.sv | 131 +++++++++++++
 tb/tb_prbs5_checker.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs5_checker_if.sv
// Bit-stream interface between a PRBS5 source and its checker: the sampled
// bit with its qualifiers, and the checker's lock/error status.
interface prbs5_checker_if #(
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;

    modport master (
        output bit_in, bit_valid, clear_cnt,
        input  locked, err_pulse, err_count, state
    );

    modport slave (
        input  bit_in, bit_valid, clear_cnt,
        output locked, err_pulse, err_count, state
    );
endinterface

// File: rtl/prbs5_checker.sv
// PRBS5 (x^5+x^3+1) receive checker: hunts for a non-zero seed, verifies a
// run of predictions, then flywheels and counts bit errors while locked.
module prbs5_checker #(
    parameter int LOCK_CNT   = 31,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 16
) (
    input logic           clk,
    input logic           reset,
    prbs5_checker_if.slave bus
);
    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_e;

    localparam int                 MATCH_W    = $clog2(LOCK_CNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_TGT   = MATCH_W'(LOCK_CNT);
    localparam logic [4:0]         UNLOCK_TGT = 5'(UNLOCK_ERR);

    state_e             state_q, state_d;
    logic [4:0]         r_q, r_d;
    logic [2:0]         load_q, load_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [4:0]         win_q, win_d;
    logic [4:0]         werr_q, werr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pulse_q, pulse_d;
    logic               locked_q;
    logic               pred;

    // Next bit of the sequence from the five most recent bits (r[4] newest).
    assign pred = r_q[2] ^ r_q[0];

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
        state_d = state_q;
        r_d     = r_q;
        load_d  = load_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (bus.bit_valid) begin
            unique case (state_q)
                HUNT: begin
                    r_d    = {bus.bit_in, r_q[4:1]};
                    load_d = (load_q == 3'd5) ? 3'd5 : load_q + 3'd1;
                    // An all-zero history is the LFSR lockup state and never seeds verification.
                    if (load_d == 3'd5 && r_d != 5'b00000) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    r_d = {bus.bit_in, r_q[4:1]};
                    if (bus.bit_in == pred) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_d == LOCK_TGT) begin
                            state_d = LOCKED;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end else begin
                        state_d = HUNT;
                        load_d  = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel on the prediction so a received error cannot poison later bits.
                    r_d = {pred, r_q[4:1]};
                    if (bus.bit_in != pred) begin
                        pulse_d = 1'b1;
                        werr_d  = werr_q + 5'd1;
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (werr_d == UNLOCK_TGT) begin
                        state_d = HUNT;
                        load_d  = '0;
                    end
                    // The wrapping bit's error already landed in the ending window above.
                    if (win_q == 5'd30) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d = win_q + 5'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    load_d  = '0;
                end
            endcase
        end

        if (bus.clear_cnt) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q  <= HUNT;
            r_q      <= '0;
            load_q   <= '0;
            match_q  <= '0;
            win_q    <= '0;
            werr_q   <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            load_q   <= load_d;
            match_q  <= match_d;
            win_q    <= win_d;
            werr_q   <= werr_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            locked_q <= (state_d == LOCKED);
        end
    end

    assign bus.state     = state_q;
    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_prbs5_checker.sv
// Bench for prbs5_checker: a 16-bit and a 4-bit counter build share one stimulus
// and one sequence-table reference model; directed scenarios then random traffic.
module tb_prbs5_checker;
    localparam int LOCK_CNT   = 31;
    localparam int UNLOCK_ERR = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic b = 1'b0, v = 1'b0, c = 1'b0;
    always #5 clk = ~clk;

    prbs5_checker_if #(.CNT_W(16)) if16 ();
    prbs5_checker_if #(.CNT_W(4))  if4 ();
    assign if16.bit_in = b;  assign if16.bit_valid = v;  assign if16.clear_cnt = c;
    assign if4.bit_in  = b;  assign if4.bit_valid  = v;  assign if4.clear_cnt  = c;

    prbs5_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(16)) u_dut16 (
        .clk(clk), .reset(reset), .bus(if16.slave));
    prbs5_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference sequence: one period of the generator output from seed 00001.
    bit seq[31];
    int sidx;

    // Model: mode 0 hunt, 1 verify, 2 locked; locked predictions come from seq[] by phase.
    int          m_mode;
    bit          m_hist[$];
    int          m_match, m_ptr, m_win, m_werr;
    int unsigned m_raw;
    bit          m_pulse;
    bit          chk_en = 1'b0;

    function automatic int find_phase();
        for (int k = 0; k < 31; k++) begin
            bit ok = 1'b1;
            for (int j = 0; j < 5; j++) if (seq[(k + j) % 31] != m_hist[j]) ok = 1'b0;
            if (ok) return (k + 5) % 31;
        end
        return 0;
    endfunction

    task automatic model_step(input bit vb, input bit bb, input bit cb, input bit rb);
        bit pr;
        int ones;
        m_pulse = 1'b0;
        if (rb) begin
            m_mode = 0; m_hist.delete(); m_raw = 0;
            m_match = 0; m_ptr = 0; m_win = 0; m_werr = 0;
            return;
        end
        if (vb) begin
            case (m_mode)
                0: begin
                    m_hist.push_back(bb);
                    if (m_hist.size() > 5) void'(m_hist.pop_front());
                    ones = 0;
                    foreach (m_hist[i]) ones += int'(m_hist[i]);
                    if (m_hist.size() == 5 && ones != 0) begin m_mode = 1; m_match = 0; end
                end
                1: begin
                    pr = m_hist[0] ^ m_hist[2];
                    if (bb == pr) begin
                        m_hist.push_back(bb);
                        void'(m_hist.pop_front());
                        m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_mode = 2; m_ptr = find_phase(); m_win = 0; m_werr = 0;
                        end
                    end else begin
                        m_mode = 0; m_hist.delete();
                    end
                end
                default: begin
                    pr = seq[m_ptr];
                    m_ptr = (m_ptr + 1) % 31;
                    m_win++;
                    if (bb != pr) begin
                        m_pulse = 1'b1; m_werr++;
                        if (m_raw < 65535) m_raw++;
                    end
                    if (m_werr == UNLOCK_ERR) begin
                        m_mode = 0; m_hist.delete();
                    end else if (m_win == 31) begin
                        m_win = 0; m_werr = 0;
                    end
                end
            endcase
        end
        if (cb) m_raw = 0;
    endtask

    // Every cycle after the first reset, both builds are compared with the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("state16",  32'(if16.state),     32'(m_mode));
            check("locked16", 32'(if16.locked),    32'(m_mode == 2));
            check("pulse16",  32'(if16.err_pulse), 32'(m_pulse));
            check("count16",  32'(if16.err_count), m_raw);
            check("state4",   32'(if4.state),      32'(m_mode));
            check("locked4",  32'(if4.locked),     32'(m_mode == 2));
            check("pulse4",   32'(if4.err_pulse),  32'(m_pulse));
            check("count4",   32'(if4.err_count),  (m_raw > 15) ? 32'd15 : m_raw);
        end
    end

    task automatic step(input bit vb, input bit bb, input bit cb, input bit rb);
        @(negedge clk);
        reset = rb; v = vb; b = bb; c = cb;
        model_step(vb, bb, cb, rb);
        if (rb) chk_en = 1'b1;
    endtask

    task automatic send(input bit inv, input bit cb = 1'b0);
        step(1'b1, seq[sidx % 31] ^ inv, cb, 1'b0);
        sidx++;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    int garbage_left;

    initial begin
        seq[0] = 1; seq[1] = 0; seq[2] = 0; seq[3] = 0; seq[4] = 0;
        for (int n = 5; n < 31; n++) seq[n] = seq[n - 3] ^ seq[n - 5];

        // Reset wins over valid and clear.
        step(1, 1, 1, 1);
        step(1, 1, 1, 1);
        settle();
        check("lit_reset_state", 32'(if16.state), 0);
        check("lit_reset_locked", 32'(if16.locked), 0);
        check("lit_reset_count", 32'(if16.err_count), 0);
        check("lit_seq_head", {26'd0, seq[5], seq[4], seq[3], seq[2], seq[1], seq[0]}, 6'b100001);

        // Acquisition from seed 00001: VERIFY after bit 5, lock on bit 36.
        sidx = 0;
        for (int i = 1; i <= 36; i++) begin
            send(0);
            if (i == 5)  begin settle(); check("lit_verify_after5", 32'(if16.state), 1); end
            if (i == 35) begin settle(); check("lit_unlocked_35", 32'(if16.locked), 0); end
        end
        settle();
        check("lit_locked_36", 32'(if16.locked), 1);
        check("lit_count_36", 32'(if16.err_count), 0);

        // One inverted bit: one pulse, count 1, lock kept through 31 clean bits.
        send(1);
        settle();
        check("lit_single_pulse", 32'(if16.err_pulse), 1);
        check("lit_single_count", 32'(if16.err_count), 1);
        send(0);
        settle();
        check("lit_pulse_drop", 32'(if16.err_pulse), 0);
        for (int i = 0; i < 30; i++) send(0);
        settle();
        check("lit_single_hold", 32'(if16.err_count), 1);
        check("lit_single_locked", 32'(if16.locked), 1);

        // Four errors in one window drop lock; clean stream relocks 36 bits later.
        for (int k = 0; k < 4; k++) begin
            send(1);
            if (k == 3) begin
                settle();
                check("lit_unlock", 32'(if16.locked), 0);
                check("lit_unlock_count", 32'(if16.err_count), 5);
            end
            send(0);
            send(0);
        end
        for (int i = 0; i < 33; i++) send(0);
        settle();
        check("lit_relock_35", 32'(if16.locked), 0);
        send(0);
        settle();
        check("lit_relock_36", 32'(if16.locked), 1);
        check("lit_relock_count", 32'(if16.err_count), 5);

        // Clear coincident with an error: clear wins, pulse still fires.
        send(1, 1);
        settle();
        check("lit_clear_count", 32'(if16.err_count), 0);
        check("lit_clear_pulse", 32'(if16.err_pulse), 1);

        // Finish this window, then 18 errors at 3 per window: 4-bit build saturates.
        for (int i = 0; i < 30; i++) send(0);
        for (int w = 0; w < 6; w++)
            for (int i = 0; i < 31; i++) send(i % 10 == 0 && i < 30);
        settle();
        check("lit_sat4", 32'(if4.err_count), 15);
        check("lit_sat16", 32'(if16.err_count), 18);
        check("lit_sat_locked", 32'(if4.locked), 1);

        // All-zero stream never leaves HUNT.
        step(0, 0, 0, 1);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0);
        settle();
        check("lit_zero_state", 32'(if16.state), 0);
        check("lit_zero_locked", 32'(if16.locked), 0);

        // Valid every third cycle with garbage between: lock on 36th valid bit.
        step(0, 0, 0, 1);
        sidx = 0;
        for (int i = 1; i <= 36; i++) begin
            step(0, 1'($urandom), 0, 0);
            step(0, 1'($urandom), 0, 0);
            send(0);
            if (i == 35) begin settle(); check("lit_sparse_35", 32'(if16.locked), 0); end
        end
        settle();
        check("lit_sparse_36", 32'(if16.locked), 1);

        // Random traffic: gaps, sparse errors, garbage bursts, clears, resets.
        garbage_left = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 8) begin
                step(1'($urandom), 1'($urandom), 1'($urandom), 1);
            end else if (r < 150) begin
                step(0, 1'($urandom), r < 20, 0);
            end else if (garbage_left > 0) begin
                step(1, 1'($urandom), 0, 0);
                garbage_left--;
            end else begin
                if (r < 155) garbage_left = 20;
                send(r >= 950, r > 995);
            end
        end

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
